sample_ring_buffer: RTL and testbench

//   Producer end of the 24-bit sample read interface (ram_read_*, ram_buffer_ready) used by audio consumers.

---
 rtl/sample_ring_buffer.sv | 72 +++++++
 tb/tb_sample_ring_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ring_buffer.sv
// sample_ring_buffer: captures one I2S channel into a block-RAM ring and serves it on a valid/ready port.
// Define SAMPLE_RING_BUFFER_OVERWRITE_EN to discard the oldest entry instead of the newest when full.
module sample_ring_buffer #(
    parameter logic SELECT_LEFT     = 1'b1,
    parameter int   DEPTH           = 512,
    parameter int   READY_THRESHOLD = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [23:0]              sample_data_i,
    input  logic                     sample_valid_i,
    input  logic                     sample_left_i,
    input  logic                     clear_i,
    output logic [23:0]              ram_read_data_o,
    output logic                     ram_read_valid_o,
    input  logic                     ram_read_ready_i,
    output logic                     ram_buffer_ready_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   fill_level_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t        state;
    logic [23:0]   mem [DEPTH];
    logic [23:0]   ram_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          accept, issue, full, lost, store, drop_oldest, handshake;

    assign accept    = sample_valid_i && (sample_left_i == SELECT_LEFT);
    assign issue     = (state == IDLE) && (fill_level_o != '0);
    assign full      = fill_level_o == (AW+1)'(DEPTH);
    assign lost      = accept && full && !issue;
    assign handshake = (state == HOLD) && ram_read_valid_o && ram_read_ready_i;
`ifdef SAMPLE_RING_BUFFER_OVERWRITE_EN
    assign store       = accept;
    assign drop_oldest = lost;
`else
    assign store       = accept && (!full || issue);
    assign drop_oldest = 1'b0;
`endif

    // RAM kept free of reset so it maps onto block RAM; a full overwrite reads the old entry first
    always_ff @(posedge clk_i) begin
        if (store && rst_ni && !clear_i) mem[wr_ptr] <= sample_data_i;
        if (issue) ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fill_level_o       <= '0;
            state              <= IDLE;
            ram_read_valid_o   <= 1'b0;
            ram_buffer_ready_o <= 1'b0;
            overflow_o         <= 1'b0;
            if (!rst_ni) ram_read_data_o <= '0;
        end else begin
            wr_ptr             <= wr_ptr + AW'(store);
            rd_ptr             <= rd_ptr + AW'(issue || drop_oldest);
            fill_level_o       <= fill_level_o + (AW+1)'(store && !drop_oldest) - (AW+1)'(issue);
            overflow_o         <= overflow_o | lost;
            ram_buffer_ready_o <= (fill_level_o >= (AW+1)'(READY_THRESHOLD)) ? 1'b1 :
                                  (fill_level_o == '0) ? 1'b0 : ram_buffer_ready_o;
            state              <= issue ? FETCH : (state == FETCH) ? HOLD : handshake ? IDLE : state;
            ram_read_valid_o   <= (state == FETCH) ? 1'b1 : handshake ? 1'b0 : ram_read_valid_o;
            if (state == FETCH) ram_read_data_o <= ram_q;
        end
    end
endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb_sample_ring_buffer: randomized bench for sample_ring_buffer against a queue-based reference model.
module tb_sample_ring_buffer;
    localparam int DEPTH = 8;
    localparam int THR   = 4;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [23:0] sample_data = '0;
    logic        sample_valid = 0, sample_left = 0, clear = 0, ready = 0;
    logic [23:0] rd_data;
    logic        rd_valid, buf_ready, overflow;
    logic [3:0]  fill;

    int total = 0, passed = 0, cyc = 0;

    // reference model: RAM contents as a queue plus the output slot
    logic [23:0] mq [$];
    logic [23:0] got [$];
    int          got_t [$];
    int          st = 0;
    logic [23:0] m_fetch = '0, m_data = '0;
    logic        m_valid = 0, m_ovf = 0, m_brdy = 0;

    sample_ring_buffer #(.SELECT_LEFT(1'b1), .DEPTH(DEPTH), .READY_THRESHOLD(THR)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sample_data_i(sample_data), .sample_valid_i(sample_valid),
        .sample_left_i(sample_left), .clear_i(clear), .ram_read_data_o(rd_data),
        .ram_read_valid_o(rd_valid), .ram_read_ready_i(ready), .ram_buffer_ready_o(buf_ready),
        .overflow_o(overflow), .fill_level_o(fill)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int cnt = mq.size();
        if (!rst_n || clear) begin
            mq.delete();
            st = 0; m_valid = 0; m_ovf = 0; m_brdy = 0;
            if (!rst_n) m_data = '0;
        end else begin
            m_brdy = (cnt >= THR) ? 1'b1 : (cnt == 0) ? 1'b0 : m_brdy;
            if (st == 0 && cnt > 0) begin
                m_fetch = mq.pop_front();
                st = 1;
            end else if (st == 1) begin
                m_data = m_fetch; m_valid = 1; st = 2;
            end else if (st == 2 && ready) begin
                m_valid = 0; st = 0;
            end
            if (sample_valid && sample_left) begin
                if (mq.size() < DEPTH) mq.push_back(sample_data);
                else begin
                    m_ovf = 1;
`ifdef SAMPLE_RING_BUFFER_OVERWRITE_EN
                    void'(mq.pop_front());
                    mq.push_back(sample_data);
`endif
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit l, input logic [23:0] d, input bit r, input bit c);
        sample_valid = v; sample_left = l; sample_data = d; ready = r; clear = c;
        if (rd_valid && r && rst_n && !c) begin
            got.push_back(rd_data);
            got_t.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [30:0] expv();
        return {m_valid, m_data, 4'(mq.size()), m_ovf, m_brdy};
    endfunction

    task automatic test_reset();
        int lat = 0;
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 24'($urandom), 1, 0);
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== 31'h0)
                $display("FAIL reset: got %h want 0", {rd_valid, rd_data, fill, overflow, buf_ready});
            else passed++;
        end
        rst_n = 1;
        drive(1, 1, 24'h0abcde, 1, 0);
        while (!rd_valid && lat < 10) begin
            drive(0, 0, 0, 1, 0);
            lat++;
        end
        total++;
        if (lat !== 2 || rd_data !== 24'h0abcde)
            $display("FAIL first_latency: got %0d cycles data %h want 2 cycles data 0abcde", lat, rd_data);
        else passed++;
        total++;
        if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
            $display("FAIL first_model: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
        else passed++;
    endtask

    task automatic test_left_only();
        drive(0, 0, 0, 1, 1);
        got.delete(); got_t.delete();
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 24'(i), 1, 0);
            drive(1, 0, 24'($urandom) | 24'h800000, 1, 0);
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL left_only_model: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 1, 0);
        total++;
        if (got.size() !== 16) $display("FAIL left_only_count: got %0d want 16", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 16; i++) begin
            total++;
            if (got[i] !== 24'(i + 1)) $display("FAIL left_only_order[%0d]: got %h want %h", i, got[i], 24'(i + 1));
            else passed++;
            if (i > 0) begin
                total++;
                if (got_t[i] - got_t[i-1] !== 3)
                    $display("FAIL left_only_spacing[%0d]: got %0d want 3", i, got_t[i] - got_t[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_threshold();
        bit seen = 0;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(i < 5, 1, 24'(100 + i), 0, 0);
            seen |= buf_ready;
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL threshold_fill: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
        for (int i = 0; i < 30; i++) begin
            drive(0, 0, 0, 1, 0);
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL threshold_drain: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
        total++;
        if (!seen || buf_ready !== 1'b0) $display("FAIL threshold_edges: seen %0b end %0b want 1 0", seen, buf_ready);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [23:0] want [$];
        drive(0, 0, 0, 0, 1);
        got.delete();
        for (int i = 1; i <= 10; i++) drive(1, 1, 24'(i), 0, 0);
        drive(0, 0, 0, 0, 0);
        total++;
        if (fill !== 4'd8 || overflow !== 1'b1 || {rd_valid, rd_data} !== {1'b1, 24'd1})
            $display("FAIL overflow_state: got fill %0d ovf %0b data %h want 8 1 000001", fill, overflow, rd_data);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 1, 0);
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL overflow_drain: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
`ifdef SAMPLE_RING_BUFFER_OVERWRITE_EN
        want.push_back(1);
        for (int i = 3; i <= 10; i++) want.push_back(24'(i));
`else
        for (int i = 1; i <= 9; i++) want.push_back(24'(i));
`endif
        total++;
        if (got != want) $display("FAIL overflow_sequence: got %p want %p", got, want);
        else passed++;
    endtask

    task automatic test_hold_clear();
        logic [23:0] d0;
        drive(1, 1, 24'h7f00aa, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        d0 = rd_data;
        for (int i = 0; i < 20; i++) begin
            drive($urandom_range(0, 1), 0, 24'($urandom), 0, 0);
            total++;
            if ({rd_valid, rd_data} !== {1'b1, 24'h7f00aa} || {rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL hold_stable: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
        drive(1, 1, 24'h123456, 1, 1);
        total++;
        if ({rd_valid, fill, overflow, buf_ready} !== 7'h0 || rd_data !== d0)
            $display("FAIL clear: got v%0b f%0d o%0b d%h want 0 0 0 %h", rd_valid, fill, overflow, rd_data, d0);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [23:0] sent [$];
        int n = 3 * DEPTH + 5;
        bit v;
        drive(0, 0, 0, 0, 1);
        got.delete();
        for (int c = 0; c < 2000 && got.size() < n; c++) begin
            v = sent.size() < n && $urandom_range(0, 1) == 1 && mq.size() < DEPTH - 1;
            if (v) begin
                sent.push_back(24'($urandom));
                drive(1, 1, sent[$], $urandom_range(0, 3) != 0, 0);
            end else drive($urandom_range(0, 1), 0, 24'($urandom), $urandom_range(0, 3) != 0, 0);
            total++;
            if ({rd_valid, rd_data, fill, overflow, buf_ready} !== expv())
                $display("FAIL wrap_model: got %h want %h", {rd_valid, rd_data, fill, overflow, buf_ready}, expv());
            else passed++;
        end
        total++;
        if (got != sent) $display("FAIL wrap_sequence: got %0d samples want %0d in order", got.size(), sent.size());
        else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_left_only();
        test_threshold();
        test_overflow();
        test_hold_clear();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
